// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the single-cycle MIPS datapath blocks.
//   DEF_DATA_W / DEF_ADDR_W : default word and register-address widths
//   word_t / reg_addr_t     : matching data and register-index types
//   REG_ZERO, REG_SP, REG_RA: architecturally named register indices
package mips_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP   = 5'd29;
    localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/register_bank_if.sv
// register_bank_if: bundles the register-file access signals.
//   a1, a2      : read addresses (rs, rt)
//   a3, wd3, we3: write address, data and enable from writeback
//   rd1, rd2    : combinational read data
// master drives the addresses and write data; slave is the register file side.
interface register_bank_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);

    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd3;
    logic              we3;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    modport master (
        output a1, a2, a3, wd3, we3,
        input  rd1, rd2
    );

    modport slave (
        input  a1, a2, a3, wd3, we3,
        output rd1, rd2
    );

endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port of the register file.
//   i_regs : full storage array
//   i_addr : register index to read
//   o_data : selected word; index 0 always reads as zero
module regfile_read_port #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic [DATA_W-1:0] i_regs [0:(2**ADDR_W)-1],
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    // The zero check keeps $zero reading 0 even before the first reset, when
    // the storage behind it is still undefined.
    always_comb begin
        o_data = '0;
        if (i_addr != '0) begin
            o_data = i_regs[i_addr];
        end
    end

endmodule

// File: rtl/register_bank.sv
// register_bank: 32 x 32-bit MIPS general-purpose register file.
//   a1 / rd1 : rs read port (combinational)
//   a2 / rd2 : rt read port (combinational)
//   a3, wd3, we3 : synchronous write port; writes to register 0 are dropped
//   clk      : clock, all state changes on its rising edge
//   rst      : synchronous active-high reset, clears every register
// Ports keep the legacy positional order so old 8-port instantiations still bind.
module register_bank
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we3,
    input  logic              clk,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              rst
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Name and [0:DEPTH-1] ordering are referenced hierarchically by benches.
    logic [DATA_W-1:0] registers [0:DEPTH-1];

    // rst is compared against 1'b1 so a floating (unconnected) reset reads as
    // inactive. A write with an unknown enable or address fails its condition
    // and leaves storage untouched.
    always_ff @(posedge clk) begin
        if (rst == 1'b1) begin
            for (int i = 0; i < DEPTH; i++) begin
                registers[i] <= '0;
            end
        end else if ((we3 == 1'b1) && (a3 != '0)) begin
            registers[a3] <= wd3;
        end
    end

    // No write-to-read bypass: reads see the pre-edge contents.
    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_rs (
        .i_regs (registers),
        .i_addr (a1),
        .o_data (rd1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_rt (
        .i_regs (registers),
        .i_addr (a2),
        .o_data (rd2)
    );

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed self-checking bench for register_bank.
module tb_register_bank;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    register_bank_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    register_bank #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .a1  (bus.a1),
        .a2  (bus.a2),
        .a3  (bus.a3),
        .wd3 (bus.wd3),
        .we3 (bus.we3),
        .clk (clk),
        .rd1 (bus.rd1),
        .rd2 (bus.rd2),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_v;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus.a1   = '0;
        bus.a2   = '0;
        bus.a3   = '0;
        bus.wd3  = '0;
        bus.we3  = 1'b0;
        tick();
        rst = 1'b0;

        // Idle: we3=0 must never change storage.
        bus.a1  = 5'd10;
        bus.a2  = 5'd2;
        bus.a3  = 5'd8;
        bus.wd3 = 32'd16;
        tick();
        tick();
        tick();
        check("idle_rd1", bus.rd1, 32'd0);
        check("idle_rd2", bus.rd2, 32'd0);
        check("idle_reg8", dut.registers[8], 32'd0);

        // Basic write of 16 to register 8.
        bus.we3 = 1'b1;
        tick();
        bus.we3 = 1'b0;
        check("write_reg8", dut.registers[8], 32'd16);
        bus.a1 = 5'd8;
        #1;
        check("write_rd1", bus.rd1, 32'd16);

        // Writes to $zero are dropped.
        bus.a3  = 5'd0;
        bus.wd3 = 32'hFFFF_FFFF;
        bus.we3 = 1'b1;
        tick();
        bus.we3 = 1'b0;
        check("zero_reg0", dut.registers[0], 32'd0);
        bus.a1 = 5'd0;
        bus.a2 = 5'd0;
        #1;
        check("zero_rd1", bus.rd1, 32'd0);
        check("zero_rd2", bus.rd2, 32'd0);

        // Dual read of the register being written: old value until the edge.
        bus.a1  = 5'd5;
        bus.a2  = 5'd5;
        bus.a3  = 5'd5;
        bus.wd3 = 32'hA5A5_0001;
        bus.we3 = 1'b1;
        #1;
        check("nobypass_rd1", bus.rd1, 32'd0);
        check("nobypass_rd2", bus.rd2, 32'd0);
        tick();
        bus.we3 = 1'b0;
        check("dual_rd1", bus.rd1, 32'hA5A5_0001);
        check("dual_rd2", bus.rd2, 32'hA5A5_0001);

        // we3=0 with a live address and data leaves register 5 alone.
        bus.wd3 = 32'h1234_5678;
        tick();
        check("we0_hold", bus.rd1, 32'hA5A5_0001);

        // Fill 1..31 with own index, then reset with a simultaneous write.
        for (int i = 1; i < 32; i++) begin
            bus.a3  = 5'(i);
            bus.wd3 = 32'(i);
            bus.we3 = 1'b1;
            tick();
        end
        bus.we3 = 1'b0;
        check("fill_reg7", dut.registers[7], 32'd7);
        check("fill_reg31", dut.registers[31], 32'd31);
        rst     = 1'b1;
        bus.a3  = 5'd7;
        bus.wd3 = 32'd99;
        bus.we3 = 1'b1;
        tick();
        rst     = 1'b0;
        bus.we3 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.a1 = 5'(i);
            bus.a2 = 5'(31 - i);
            #1;
            check($sformatf("rst_reg%0d", i), dut.registers[i], 32'd0);
            check($sformatf("rst_rd1_%0d", i), bus.rd1, 32'd0);
            check($sformatf("rst_rd2_%0d", 31 - i), bus.rd2, 32'd0);
        end

        // Sweep: register i holds i*3.
        for (int i = 1; i < 32; i++) begin
            bus.a3  = 5'(i);
            bus.wd3 = 32'(i * 3);
            bus.we3 = 1'b1;
            tick();
        end
        bus.we3 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.a1 = 5'(i);
            bus.a2 = 5'(i);
            #1;
            exp_v = 32'(i * 3);
            check($sformatf("sweep_rd1_%0d", i), bus.rd1, exp_v);
            check($sformatf("sweep_rd2_%0d", i), bus.rd2, exp_v);
        end

        // Unknown write address must not touch storage.
        bus.a3  = 5'bxxxxx;
        bus.wd3 = 32'hDEAD_BEEF;
        bus.we3 = 1'b1;
        tick();
        bus.we3 = 1'b0;
        bus.a3  = 5'd0;
        for (int i = 0; i < 32; i++) begin
            bus.a1 = 5'(i);
            #1;
            exp_v = 32'(i * 3);
            check($sformatf("xaddr_rd1_%0d", i), bus.rd1, exp_v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
